// File: rtl/alu_mul_seq_pkg.sv
// Shared constants and types for the shift-and-add multiplier sequencer.
// Holds the FSM state encoding, datapath widths and the fixed ALU control word.
package alu_mul_seq_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ITER    = 16;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_ADD  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DBL  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    // ALU control word, field order {zx,nx,zy,ny,f,no}
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // x + y: no zeroing, no negation, adder selected, output not inverted
    localparam alu_ctrl_t ALU_CTRL_ADD = alu_ctrl_t'(6'b000010);

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bundle between a requester and the multiplier sequencer.
//   start, a, b      : request and operands (requester -> sequencer)
//   busy, done, p    : status and registered product (sequencer -> requester)
//   zr, ng           : flags derived combinationally from p
interface alu_mul_seq_if;
    import alu_mul_seq_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] p;
    logic              zr;
    logic              ng;

    modport master (output start, a, b, input busy, done, p, zr, ng);
    modport slave  (input start, a, b, output busy, done, p, zr, ng);
endinterface

// File: rtl/alu_mul_seq_alu.sv
// The existing 16-bit zx/nx/zy/ny/f/no ALU (combinational).
//   ctrl  : control word
//   x, y  : operands
//   out_c : result
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
(
    input  alu_ctrl_t         ctrl,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] out_c
);

    logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

    // Operand preconditioning, function select, output inversion
    always_comb begin
        x_z   = ctrl.zx ? '0 : x;
        x_n   = ctrl.nx ? ~x_z : x_z;
        y_z   = ctrl.zy ? '0 : y;
        y_n   = ctrl.ny ? ~y_z : y_z;
        f_out = ctrl.f ? (x_n + y_n) : (x_n & y_n);
        out_c = ctrl.no ? ~f_out : f_out;
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 16-bit shift-and-add multiplier that reuses the single ALU for
// both the accumulate (acc+mc) and the multiplicand doubling (mc+mc).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of alu_mul_seq_if (start/a/b in, busy/done/p/zr/ng out)
//   EARLY_EXIT : 1 = stop once the remaining multiplier bits are zero
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_mul_seq_if.slave bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  mc_q, mc_d;
    logic [DATA_W-1:0]  mp_q, mp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DATA_W-1:0]  alu_x;
    logic [DATA_W-1:0]  alu_out_c;

    // ALU x operand: accumulator while adding, multiplicand while doubling
    always_comb begin
        alu_x = (state_q == ST_ADD) ? acc_q : mc_q;
    end

    alu_mul_seq_alu u_alu (
        .ctrl  (ALU_CTRL_ADD),
        .x     (alu_x),
        .y     (mc_q),
        .out_c (alu_out_c)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    mc_d    = bus.a;
                    mp_d    = bus.b;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (mp_q[0]) begin
                    acc_d = alu_out_c;
                end
                state_d = ST_DBL;
            end
            ST_DBL: begin
                mc_d  = alu_out_c;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                // acc_q already holds this iteration's ADD result here
                if ((cnt_q == CNT_W'(ITER - 1)) ||
                    (EARLY_EXIT && (mp_q[DATA_W-1:1] == '0))) begin
                    p_d     = acc_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they are registered
        busy_d = (state_d == ST_ADD) || (state_d == ST_DBL);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
    assign bus.zr   = (p_q == '0);
    assign bus.ng   = p_q[DATA_W-1];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: one instance per EARLY_EXIT setting,
// directed scenarios plus randomized operands against an arithmetic model.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_r;
    logic [15:0] a_r, b_r;
    bit          sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mul_seq_if if0 ();
    alu_mul_seq_if if1 ();

    assign if0.start = start_r & ~sel;
    assign if1.start = start_r & sel;
    assign if0.a = a_r;
    assign if0.b = b_r;
    assign if1.a = a_r;
    assign if1.b = b_r;

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    wire        busy_s = sel ? if1.busy : if0.busy;
    wire        done_s = sel ? if1.done : if0.done;
    wire [15:0] p_s    = sel ? if1.p    : if0.p;
    wire        zr_s   = sel ? if1.zr   : if0.zr;
    wire        ng_s   = sel ? if1.ng   : if0.ng;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: product modulo 2^16
    function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = 32'(a) * 32'(b);
        return full[15:0];
    endfunction

    // Reference: cycle in which done is expected (start sampled in cycle 0)
    function automatic int ref_done_cyc(input bit ee, input logic [15:0] b);
        int k;
        if (!ee) return 33;
        k = 1;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        return 2 * k + 1;
    endfunction

    // Issue one request in cycle 0 and observe until done (bounded)
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input bit hold, input bit mutate,
                         output int done_cyc, output int done_cnt, output int busy_cnt,
                         output bit busy_dn, output logic [15:0] p_at,
                         output bit zr_at, output bit ng_at, output bit p_moved,
                         output bit done_after, output bit busy_after);
        logic [15:0] p0;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_dn = 1'b0;
        p_at = 16'hxxxx; zr_at = 1'b0; ng_at = 1'b0; p_moved = 1'b0;
        done_after = 1'b0; busy_after = 1'b0;
        p0 = p_s;
        a_r = a; b_r = b; start_r = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (!hold) start_r = 1'b0;
            if (mutate) begin a_r = 16'($urandom); b_r = 16'($urandom); end
            if (done_s) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; p_at = p_s; zr_at = zr_s; ng_at = ng_s; busy_dn = busy_s;
                end
            end else begin
                if (busy_s) busy_cnt++;
                if (p_s !== p0) p_moved = 1'b1;
            end
            if (done_cyc >= 0) break;
        end
        if (!hold) begin
            start_r = 1'b0;
            tick;
            done_after = done_s;
            busy_after = busy_s;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_r = 1'b0; a_r = '0; b_r = '0; sel = 1'b0;
        repeat (3) tick;
        n_tests++;
        if ({if0.busy, if0.done, if0.p, if0.zr, if0.ng} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ee0: busy=%b done=%b p=%h zr=%b ng=%b, want 0 0 0000 1 0",
                     if0.busy, if0.done, if0.p, if0.zr, if0.ng);
        end
        n_tests++;
        if ({if1.busy, if1.done, if1.p, if1.zr, if1.ng} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ee1: busy=%b done=%b p=%h zr=%b ng=%b, want 0 0 0000 1 0",
                     if1.busy, if1.done, if1.p, if1.zr, if1.ng);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int dc, dn, bc; bit bd, z, n, pm, da, ba; logic [15:0] p;
        sel = 1'b0;
        do_op(16'd3, 16'd5, 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if (dc !== 33) begin n_fail++; $display("FAIL basic_latency: done at %0d, want 33", dc); end
        n_tests++;
        if (bc !== 32 || bd !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy: busy cycles=%0d busy_at_done=%b, want 32 0", bc, bd);
        end
        n_tests++;
        if ({p, z, n} !== {16'h000F, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL basic_result: p=%h zr=%b ng=%b, want 000f 0 0", p, z, n);
        end
        n_tests++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse: cycle34 done=%b busy=%b, want 0 0", da, ba);
        end
    endtask

    task automatic test_wrap;
        int dc, dn, bc; bit bd, z, n, pm, da, ba; logic [15:0] p;
        sel = 1'b0;
        do_op(16'hFFFF, 16'h0002, 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if ({p, z, n} !== {16'hFFFE, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wrap_neg: p=%h zr=%b ng=%b, want fffe 0 1", p, z, n);
        end
        do_op(16'h0100, 16'h0100, 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if ({p, z, n} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL wrap_zero: p=%h zr=%b ng=%b, want 0000 1 0", p, z, n);
        end
    endtask

    task automatic test_hold;
        int dc, dn, bc, c2; bit bd, z, n, pm, da, ba; logic [15:0] p;
        sel = 1'b0;
        do_op(16'h0012, 16'h0034, 1'b1, 1'b1, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if (dc !== 33 || dn !== 1) begin
            n_fail++; $display("FAIL hold_first: done at %0d count %0d, want 33 1", dc, dn);
        end
        n_tests++;
        if (p !== 16'h03A8) begin n_fail++; $display("FAIL hold_captured: p=%h, want 03a8", p); end
        a_r = 16'h0101; b_r = 16'h0003;
        tick;
        n_tests++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            n_fail++; $display("FAIL hold_idle34: busy=%b done=%b, want 0 0", busy_s, done_s);
        end
        tick;
        start_r = 1'b0;
        n_tests++;
        if (busy_s !== 1'b1) begin n_fail++; $display("FAIL hold_accept35: busy=%b, want 1", busy_s); end
        c2 = -1;
        for (int c = 35; c <= 80; c++) begin
            if (done_s) begin c2 = c; break; end
            tick;
        end
        n_tests++;
        if (c2 !== 67 || p_s !== 16'h0303) begin
            n_fail++; $display("FAIL hold_second: done at %0d p=%h, want 67 0303", c2, p_s);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int dc, dn, bc, pulses; bit bd, z, n, pm, da, ba; logic [15:0] p;
        sel = 1'b0;
        a_r = 16'h0055; b_r = 16'h0077; start_r = 1'b1;
        tick;
        start_r = 1'b0;
        repeat (9) tick;
        rst_n = 1'b0;
        tick;
        n_tests++;
        if ({busy_s, done_s, p_s, zr_s, ng_s} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b p=%h zr=%b ng=%b, want 0 0 0000 1 0",
                     busy_s, done_s, p_s, zr_s, ng_s);
        end
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick;
            if (done_s) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin n_fail++; $display("FAIL reset_no_done: %0d pulses, want 0", pulses); end
        do_op(16'h0055, 16'h0077, 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if (dc !== 33 || p !== 16'h2783) begin
            n_fail++; $display("FAIL reset_restart: done at %0d p=%h, want 33 2783", dc, p);
        end
    endtask

    task automatic test_early_exit;
        logic [15:0] ta[3] = '{16'd7, 16'd7, 16'd2};
        logic [15:0] tb[3] = '{16'd1, 16'd0, 16'h8000};
        int          tc[3] = '{3, 3, 33};
        logic [15:0] tp[3] = '{16'd7, 16'd0, 16'd0};
        int dc, dn, bc; bit bd, z, n, pm, da, ba; logic [15:0] p;
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
            n_tests++;
            if (dc !== tc[i] || p !== tp[i] || bc !== tc[i] - 1) begin
                n_fail++;
                $display("FAIL early_%0d: done at %0d p=%h busy=%0d, want %0d %h %0d",
                         i, dc, p, bc, tc[i], tp[i], tc[i] - 1);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back;
        int dc, dn, bc; bit bd, z, n, pm, da, ba; logic [15:0] p;
        sel = 1'b0;
        do_op(16'h1234, 16'h0003, 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if (p !== 16'h369C) begin n_fail++; $display("FAIL b2b_first: p=%h, want 369c", p); end
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, dc, dn, bc, bd, p, z, n, pm, da, ba);
        n_tests++;
        if (pm !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: p changed before done, want held 369c"); end
        n_tests++;
        if (p !== 16'h0001 || dc !== 33) begin
            n_fail++; $display("FAIL b2b_second: p=%h done at %0d, want 0001 33", p, dc);
        end
    endtask

    task automatic test_random;
        int dc, dn, bc, ec; bit bd, z, n, pm, da, ba; logic [15:0] p, ra, rb, ep;
        for (int ee = 0; ee < 2; ee++) begin
            sel = 1'(ee);
            for (int t = 0; t < 12; t++) begin
                ra = 16'($urandom);
                rb = 16'($urandom >> $urandom_range(16, 32));
                ep = ref_prod(ra, rb);
                ec = ref_done_cyc(sel, rb);
                do_op(ra, rb, 1'b0, 1'($urandom_range(0, 1)), dc, dn, bc, bd, p, z, n, pm, da, ba);
                n_tests++;
                if (p !== ep || z !== (ep == 16'h0) || n !== ep[15] || dc !== ec || bc !== ec - 1) begin
                    n_fail++;
                    $display("FAIL rand_ee%0d_%0d: a=%h b=%h p=%h zr=%b ng=%b done at %0d busy=%0d, want p=%h zr=%b ng=%b done %0d busy %0d",
                             ee, t, ra, rb, p, z, n, dc, bc, ep, ep == 16'h0, ep[15], ec, ec - 1);
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_hold;
        test_reset_mid;
        test_early_exit;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle 16-bit multiplier sequencer built around the existing 16-bit ALU (zx/nx/zy/ny/f/no control).
It uses the single ALU for all additions and doublings in a shift-and-add loop, with a start/busy/done handshake.
It gives the CPU-level datapath a multiply without adding a second adder.
The result is the product modulo 2^16, so the two's-complement low word is correct for signed and unsigned operands.

Parameters:
EARLY_EXIT, 0, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = fixed 16-iteration latency.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE
a  input  16  multiplicand, captured on accepted start
b  input  16  multiplier, captured on accepted start
busy  output  1  high in ADD and DBL states
done  output  1  single-cycle pulse in DONE state
p  output  16  registered product; holds until next completion
zr  output  1  p == 0 (combinational from p)
ng  output  1  p[15] (combinational from p)

Behaviour:
- One clock domain. rst_n is sampled on the clk rising edge; rst_n=0 forces the following state:
  - state=IDLE
  - internal registers acc, mc, mp, cnt all cleared
  - p=0, busy=0, done=0, hence zr=1 and ng=0
- Registers:
  - acc[16]: accumulator
  - mc[16]: shifted multiplicand
  - mp[16]: remaining multiplier bits
  - cnt[4]: iteration count
- ALU hookup:
  - Control is fixed at zx=0, nx=0, zy=0, ny=0, f=1, no=0, so ALU out = x+y.
  - y = mc.
  - x = acc in ADD, mc in DBL; x is don't-care in other states.
- IDLE:
  - busy=0, done=0.
  - If start=1: acc<=0, mc<=a, mp<=b, cnt<=0, go to ADD.
- ADD:
  - If mp[0]=1, acc <= ALU out (acc+mc); otherwise acc holds.
  - Always go to DBL.
- DBL:
  - mc <= ALU out (mc+mc), mp <= mp>>1 (logical), cnt <= cnt+1.
  - Go to DONE if cnt==15, or if EARLY_EXIT=1 and (mp>>1)==0.
  - Otherwise go to ADD.
  - On the DONE transition, p <= final acc, which must include any ADD in this iteration.
- DONE:
  - done=1, busy=0, go to IDLE.
  - start is ignored in this cycle; it is not queued.
- Latency with EARLY_EXIT=0:
  - start sampled high in cycle 0, ADD/DBL occupy cycles 1..32, done=1 in cycle 33.
  - Next start can be accepted in cycle 34.
- Latency with EARLY_EXIT=1: done falls in cycle 2k+1, where k = max(1, index of the highest set bit of b + 1). b=0 gives k=1.
- Arithmetic:
  - All sums wrap modulo 2^16; carry-out of the adder is discarded.
  - No overflow flag.
- start while busy or done: ignored; a and b changes during the operation have no effect.
- Reset mid-operation: the operation is abandoned, no done pulse, p=0.
- p, zr and ng change only on reset or on the DBL→DONE transition.

Decomposition:
- Shared package constants:
  - state encoding: IDLE=2'd0, ADD=2'd1, DBL=2'd2, DONE=2'd3
  - ALU add control vector: {zx,nx,zy,ny,f,no} = 6'b000010
  - ITER=16
- One sub-module: the existing ALU, instantiated once.
- Control FSM and registers live in alu_mul_seq.

Test Plan:
1. EARLY_EXIT=0, a=3, b=5, start pulse in cycle 0 → busy=1 in cycles 1..32; done=1 only in cycle 33; p=0x000F, zr=0, ng=0.
2. a=0xFFFF, b=2 → p=0xFFFE, ng=1, zr=0. Then a=0x0100, b=0x0100 → p=0x0000, zr=1 (wrap check).
3. Start held high through the whole operation with a/b changed mid-op → one result per accepted start, computed from the originally captured a/b; next operation accepted only in cycle 34.
4. rst_n=0 in cycle 10 of an operation → cycle after the reset edge has busy=0, done=0, p=0. No done pulse appears; a new start works normally.
5. EARLY_EXIT=1:
   - a=7, b=1 → done in cycle 3, p=7.
   - a=7, b=0 → done in cycle 3, p=0.
   - a=2, b=0x8000 → done in cycle 33, p=0.
6. Back-to-back: 0x1234*0x0003 then 0xFFFF*0xFFFF → p=0x369C, then p=0x0001. p holds 0x369C until the second done.
